// File: rtl/video_timing_pkg.sv
// Shared state encoding, line-record layout and event-flag indices for the video timing detector.
package video_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    // Line record: four positions packed as [REC_FIELDS-1:0][c-1:0]
    localparam int unsigned REC_FIELDS  = 4;
    localparam logic [1:0]  REC_S_BLANK = 2'd0;
    localparam logic [1:0]  REC_S_SYNC  = 2'd1;
    localparam logic [1:0]  REC_R_SYNC  = 2'd2;
    localparam logic [1:0]  REC_R_BLANK = 2'd3;

    localparam int unsigned EV_COUNT       = 4;
    localparam logic [1:0]  EV_LINE_START  = 2'd0;
    localparam logic [1:0]  EV_OVERFLOW    = 2'd1;
    localparam logic [1:0]  EV_WELL_FORMED = 2'd2;
    localparam logic [1:0]  EV_MATCH       = 2'd3;

    // Saturating edge counter: 0, 1, 2 and "many"
    localparam int unsigned EDGE_CNT_W = 2;

endpackage

// File: rtl/video_timing_detector_if.sv
// Blank/sync stream in, measured timing and status out; master is the video source side.
interface video_timing_detector_if #(
    parameter int unsigned c = 8
);
    logic         blank;
    logic         sync;
    logic [c-1:0] s_blank;
    logic [c-1:0] s_sync;
    logic [c-1:0] r_sync;
    logic [c-1:0] r_blank;
    logic         locked;
    logic         line_valid;
    logic         err;

    modport master (
        output blank, sync,
        input  s_blank, s_sync, r_sync, r_blank, locked, line_valid, err
    );

    modport slave (
        input  blank, sync,
        output s_blank, s_sync, r_sync, r_blank, locked, line_valid, err
    );
endinterface

// File: rtl/timing_edge_capture.sv
// Edge history for one input level: rise/fall strobes, first-edge positions and edge counts per line.
module timing_edge_capture
    import video_timing_pkg::*;
#(
    parameter int unsigned c = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  level,
    input  logic                  line_start,
    input  logic [c-1:0]          pos,
    output logic                  rise_c,
    output logic                  fall_c,
    output logic [c-1:0]          rise_pos,
    output logic [c-1:0]          fall_pos,
    output logic [EDGE_CNT_W-1:0] rise_cnt,
    output logic [EDGE_CNT_W-1:0] fall_cnt
);
    logic hist;

    assign rise_c = level & ~hist;
    assign fall_c = ~level & hist;

    // Edges on the line-start sample belong to the new line
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist     <= 1'b0;
            rise_pos <= '0;
            fall_pos <= '0;
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            hist <= level;
            if (line_start) begin
                rise_cnt <= EDGE_CNT_W'(rise_c);
                fall_cnt <= EDGE_CNT_W'(fall_c);
                rise_pos <= rise_c ? pos : '0;
                fall_pos <= fall_c ? pos : '0;
            end else begin
                if (rise_c) begin
                    if (rise_cnt == '0) rise_pos <= pos;
                    if (rise_cnt != '1) rise_cnt <= rise_cnt + EDGE_CNT_W'(1);
                end
                if (fall_c) begin
                    if (fall_cnt == '0) fall_pos <= pos;
                    if (fall_cnt != '1) fall_cnt <= fall_cnt + EDGE_CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/video_timing_detector.sv
// Measures blank/sync horizontal timing and locks once consecutive lines agree exactly.
// Define VIDEO_TIMING_DETECT_SYNC_EN to put a two-flop synchronizer on blank and sync.
module video_timing_detector
    import video_timing_pkg::*;
#(
    parameter int unsigned c = 8
) (
    input logic                    clk,
    input logic                    rst,
    video_timing_detector_if.slave vid
);
    logic blank_in;
    logic sync_in;

`ifdef VIDEO_TIMING_DETECT_SYNC_EN
    logic [1:0] blank_meta;
    logic [1:0] sync_meta;

    always_ff @(posedge clk) begin
        if (!rst) begin
            blank_meta <= '0;
            sync_meta  <= '0;
        end else begin
            blank_meta <= {blank_meta[0], vid.blank};
            sync_meta  <= {sync_meta[0], vid.sync};
        end
    end

    assign blank_in = blank_meta[1];
    assign sync_in  = sync_meta[1];
`else
    assign blank_in = vid.blank;
    assign sync_in  = vid.sync;
`endif

    state_t                       state_q, state_d;
    logic [c-1:0]                 pos_q, pos_cur;
    logic                         line_start_c, overflow_c, well_formed_c, match_c;
    logic                         shape_bad_q;
    logic [EV_COUNT-1:0]          ev;
    logic [REC_FIELDS-1:0][c-1:0] cur_rec, ref_rec, out_rec;
    logic                         locked_q, locked_d;
    logic                         line_valid_q, line_valid_d;
    logic                         err_q, err_d;
    logic                         ref_load, out_load;

    logic [c-1:0]          b_rise_pos, s_rise_pos, s_fall_pos, unused_b_fall_pos;
    logic [EDGE_CNT_W-1:0] b_rise_cnt, s_rise_cnt, s_fall_cnt, unused_b_fall_cnt;
    logic                  s_rise_c, unused_b_rise, unused_s_fall;

    // The blank falling edge is the line start
    timing_edge_capture #(.c(c)) u_blank_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (blank_in),
        .line_start (line_start_c),
        .pos        (pos_cur),
        .rise_c     (unused_b_rise),
        .fall_c     (line_start_c),
        .rise_pos   (b_rise_pos),
        .fall_pos   (unused_b_fall_pos),
        .rise_cnt   (b_rise_cnt),
        .fall_cnt   (unused_b_fall_cnt)
    );

    timing_edge_capture #(.c(c)) u_sync_edge (
        .clk        (clk),
        .rst        (rst),
        .level      (sync_in),
        .line_start (line_start_c),
        .pos        (pos_cur),
        .rise_c     (s_rise_c),
        .fall_c     (unused_s_fall),
        .rise_pos   (s_rise_pos),
        .fall_pos   (s_fall_pos),
        .rise_cnt   (s_rise_cnt),
        .fall_cnt   (s_fall_cnt)
    );

    assign pos_cur    = line_start_c ? '0 : pos_q + c'(1);
    assign overflow_c = (state_q != SEARCH) && !line_start_c && (pos_q == '1);

    // pos_q is the position of the previous sample; it idles at 0 while searching
    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_q <= '0;
        end else if (overflow_c || (state_q == SEARCH && !line_start_c)) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_cur;
        end
    end

    // Sync high at position 0, or a sync rise outside blanking, spoils the line
    always_ff @(posedge clk) begin
        if (!rst) begin
            shape_bad_q <= 1'b0;
        end else if (line_start_c) begin
            shape_bad_q <= sync_in;
        end else if (s_rise_c && !blank_in) begin
            shape_bad_q <= 1'b1;
        end
    end

    always_comb begin
        cur_rec              = '0;
        cur_rec[REC_S_BLANK] = b_rise_pos;
        cur_rec[REC_S_SYNC]  = s_rise_pos;
        cur_rec[REC_R_SYNC]  = s_fall_pos;
        cur_rec[REC_R_BLANK] = pos_q;
    end

    assign well_formed_c = (b_rise_cnt == EDGE_CNT_W'(1)) && (s_rise_cnt == EDGE_CNT_W'(1))
                        && (s_fall_cnt == EDGE_CNT_W'(1)) && !shape_bad_q
                        && (cur_rec[REC_S_BLANK] < cur_rec[REC_S_SYNC])
                        && (cur_rec[REC_S_SYNC] < cur_rec[REC_R_SYNC])
                        && (cur_rec[REC_R_SYNC] <= cur_rec[REC_R_BLANK]);
    assign match_c = (cur_rec == ref_rec);

    always_comb begin
        ev                 = '0;
        ev[EV_LINE_START]  = line_start_c;
        ev[EV_OVERFLOW]    = overflow_c;
        ev[EV_WELL_FORMED] = well_formed_c;
        ev[EV_MATCH]       = match_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= SEARCH;
        else      state_q <= state_d;
    end

    // Line-end decisions; overflow and line start never coincide
    always_comb begin
        state_d      = state_q;
        locked_d     = locked_q;
        line_valid_d = 1'b0;
        err_d        = 1'b0;
        ref_load     = 1'b0;
        out_load     = 1'b0;
        if (ev[EV_OVERFLOW]) begin
            state_d  = SEARCH;
            locked_d = 1'b0;
            err_d    = 1'b1;
        end else if (ev[EV_LINE_START]) begin
            case (state_q)
                SEARCH: state_d = MEASURE;
                MEASURE: begin
                    if (ev[EV_WELL_FORMED]) begin
                        ref_load = 1'b1;
                        state_d  = VERIFY;
                    end
                end
                VERIFY: begin
                    if (!ev[EV_WELL_FORMED]) begin
                        state_d = MEASURE;
                    end else if (ev[EV_MATCH]) begin
                        out_load     = 1'b1;
                        locked_d     = 1'b1;
                        line_valid_d = 1'b1;
                        state_d      = LOCKED;
                    end else begin
                        ref_load = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!ev[EV_WELL_FORMED]) begin
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = MEASURE;
                    end else if (ev[EV_MATCH]) begin
                        line_valid_d = 1'b1;
                    end else begin
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                        ref_load = 1'b1;
                        state_d  = VERIFY;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            locked_q     <= 1'b0;
            line_valid_q <= 1'b0;
            err_q        <= 1'b0;
            ref_rec      <= '0;
            out_rec      <= '0;
        end else begin
            locked_q     <= locked_d;
            line_valid_q <= line_valid_d;
            err_q        <= err_d;
            if (ref_load) ref_rec <= cur_rec;
            if (out_load) out_rec <= cur_rec;
        end
    end

    assign vid.s_blank    = out_rec[REC_S_BLANK];
    assign vid.s_sync     = out_rec[REC_S_SYNC];
    assign vid.r_sync     = out_rec[REC_R_SYNC];
    assign vid.r_blank    = out_rec[REC_R_BLANK];
    assign vid.locked     = locked_q;
    assign vid.line_valid = line_valid_q;
    assign vid.err        = err_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Directed bench for video_timing_detector: lock, relock, malformed lines, overflow and mid-line reset.
// Build with VIDEO_TIMING_DETECT_SYNC_EN defined to cover the synchronized input path.
module tb_video_timing_detector;

    localparam int unsigned C = 8;
`ifdef VIDEO_TIMING_DETECT_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst;

    video_timing_detector_if #(.c(C)) vid ();

    video_timing_detector #(.c(C)) dut (
        .clk (clk),
        .rst (rst),
        .vid (vid)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic lv_snap, err_snap, lock_snap;
    int   lv_cnt, err_cnt, first_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int sb, input int ss, input int rs, input int rb);
        check_eq({tag, " s_blank"}, 32'(vid.s_blank), sb);
        check_eq({tag, " s_sync"},  32'(vid.s_sync),  ss);
        check_eq({tag, " r_sync"},  32'(vid.r_sync),  rs);
        check_eq({tag, " r_blank"}, 32'(vid.r_blank), rb);
    endtask

    // One pixel; outputs are read 1 time unit after the sampling edge
    task automatic px(input logic b, input logic s);
        vid.blank = b;
        vid.sync  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pos(input int sb, input int ss, input int rs, input int p);
        px(p >= sb, (p >= ss) && (p < rs));
    endtask

    // Full line from position 0 to rb; xs..xe-1 adds an extra sync pulse
    task automatic send_line(input int sb, input int ss, input int rs, input int rb,
                             input int xs, input int xe);
        lv_cnt  = 0;
        err_cnt = 0;
        for (int p = 0; p <= rb; p++) begin
            px(p >= sb, ((p >= ss) && (p < rs)) || ((p >= xs) && (p < xe)));
            if (p == EXTRA) begin
                lv_snap   = vid.line_valid;
                err_snap  = vid.err;
                lock_snap = vid.locked;
            end
            lv_cnt  += int'(vid.line_valid);
            err_cnt += int'(vid.err);
        end
    endtask

    task automatic std_line(input int ss);
        send_line(160, ss, 200, 223, 0, 0);
    endtask

    task automatic preamble();
        for (int i = 0; i < 4; i++) px(1'b1, 1'b0);
    endtask

    initial begin
        rst       = 1'b0;
        vid.blank = 1'b0;
        vid.sync  = 1'b0;
        px(1'b0, 1'b0);
        px(1'b0, 1'b0);
        check_eq("rst locked", 32'(vid.locked), 0);
        check_eq("rst line_valid", 32'(vid.line_valid), 0);
        check_eq("rst err", 32'(vid.err), 0);
        check_pos("rst", 0, 0, 0, 0);
        rst = 1'b1;

        // Initial lock: three line starts
        preamble();
        std_line(176);
        check_eq("ls1 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("ls2 locked", 32'(lock_snap), 0);
        check_eq("ls2 line_valid", 32'(lv_snap), 0);
        check_eq("ls2 err", 32'(err_snap), 0);
        std_line(176);
        check_eq("ls3 locked", 32'(lock_snap), 1);
        check_eq("ls3 line_valid", 32'(lv_snap), 1);
        check_pos("ls3", 160, 176, 200, 223);
        std_line(176);
        check_eq("ls4 line_valid", 32'(lv_snap), 1);
        check_eq("ls4 lv count", 32'(lv_cnt), 1);
        check_eq("ls4 locked", 32'(lock_snap), 1);

        // Different but well-formed line while locked
        std_line(177);
        check_eq("diff prev match", 32'(lv_snap), 1);
        std_line(177);
        check_eq("diff err", 32'(err_snap), 1);
        check_eq("diff locked", 32'(lock_snap), 0);
        check_eq("diff hold s_sync", 32'(vid.s_sync), 176);
        std_line(177);
        check_eq("relock177 locked", 32'(lock_snap), 1);
        check_eq("relock177 line_valid", 32'(lv_snap), 1);
        check_pos("relock177", 160, 177, 200, 223);

        // Second sync pulse inside one line
        send_line(160, 177, 200, 223, 210, 215);
        std_line(177);
        check_eq("dbl err", 32'(err_snap), 1);
        check_eq("dbl locked", 32'(lock_snap), 0);
        check_eq("dbl hold s_sync", 32'(vid.s_sync), 177);
        std_line(177);
        check_eq("dbl clean1 locked", 32'(lock_snap), 0);
        check_eq("dbl clean1 err", 32'(err_snap), 0);
        check_eq("dbl clean1 line_valid", 32'(lv_snap), 0);
        std_line(177);
        check_eq("dbl clean2 locked", 32'(lock_snap), 1);
        check_eq("dbl clean2 line_valid", 32'(lv_snap), 1);

        // Overlong line: blank held low
        first_err = -1;
        err_cnt   = 0;
        for (int i = 0; i < 300; i++) begin
            px(1'b0, 1'b0);
            if (vid.err === 1'b1) begin
                err_cnt++;
                if (first_err < 0) first_err = i;
            end
        end
        check_eq("ovf first err", 32'(first_err), 256 + EXTRA);
        check_eq("ovf err count", 32'(err_cnt), 1);
        check_eq("ovf locked", 32'(vid.locked), 0);
        check_pos("ovf hold", 160, 177, 200, 223);

        // From SEARCH again: lock needs three line starts
        preamble();
        std_line(176);
        check_eq("ovf ls1 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("ovf ls2 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("ovf ls3 locked", 32'(lock_snap), 1);
        check_pos("ovf ls3", 160, 176, 200, 223);

        // Sync and blank rising on the same sample
        send_line(160, 160, 200, 223, 0, 0);
        check_eq("same-rise prev match", 32'(lv_snap), 1);
        std_line(176);
        check_eq("same-rise err", 32'(err_snap), 1);
        check_eq("same-rise locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("same-rise clean1 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("same-rise clean2 locked", 32'(lock_snap), 1);
        check_pos("same-rise relock", 160, 176, 200, 223);

        // Reset in the middle of a locked line
        for (int p = 0; p < 100; p++) drive_pos(160, 176, 200, p);
        rst = 1'b0;
        drive_pos(160, 176, 200, 100);
        check_eq("midrst locked", 32'(vid.locked), 0);
        check_eq("midrst line_valid", 32'(vid.line_valid), 0);
        check_pos("midrst", 0, 0, 0, 0);
        rst = 1'b1;
        for (int p = 101; p <= 223; p++) drive_pos(160, 176, 200, p);
        std_line(176);
        check_eq("midrst ls1 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("midrst ls2 locked", 32'(lock_snap), 0);
        std_line(176);
        check_eq("midrst ls3 locked", 32'(lock_snap), 1);
        check_pos("midrst ls3", 160, 176, 200, 223);
        std_line(176);
        check_eq("final line_valid", 32'(lv_snap), 1);
        check_eq("final err count", 32'(err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_detector.md
# video_timing_detector

Measures the horizontal timing of an incoming blank/sync pixel stream and reports the four positions a `pixel_counter` needs to regenerate it: blank start, sync start, sync end, and line end. It is the receive-side counterpart of the pixel timing generator. It sits on the video input path, clocked at pixel rate. It declares lock only after consecutive lines match exactly, and it flags malformed or overlong lines.

## Interface
Parameters:
- `c`, 8: width of the position counter and all position outputs; maximum line length is 2^c pixels.

Ports:
- `clk`  in  1  pixel clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `blank`  in  1  blanking level from the source, one sample per clock.
- `sync`  in  1  sync level from the source, active-high, one sample per clock.
- `s_blank`  out  c  position of the first `blank`=1 sample in the line.
- `s_sync`  out  c  position of the first `sync`=1 sample.
- `r_sync`  out  c  position of the first `sync`=0 sample after the sync pulse.
- `r_blank`  out  c  position of the last sample in the line (line length − 1).
- `locked`  out  1  the position outputs describe a stable, verified timing.
- `line_valid`  out  1  one-cycle pulse: a line matched while locked, or lock was just achieved.
- `err`  out  1  one-cycle pulse: malformed line, overflow, or mismatch while locked.

## Operation
- A line starts at the first sample with `blank`=0 whose previous sample had `blank`=1 (the blank falling edge). That sample is position 0, and each following sample is +1.
- A line is well-formed when all of the following hold. A line that fails any of them is malformed.
  - Exactly one blank rise, one sync rise and one sync fall occur.
  - The sync rise occurs while `blank`=1.
  - s_blank < s_sync < r_sync ≤ r_blank.
  - `sync`=0 at position 0.
- Overflow: the line reaches position 2^c−1 and the next sample is not a line start.
- FSM:
  - SEARCH. This is the reset state. Counting is inactive. On a line start, go to MEASURE.
  - MEASURE. At the next line start:
    - If the line is well-formed, store its four positions as the reference and go to VERIFY.
    - Otherwise, stay in MEASURE.
  - VERIFY. At the next line start:
    - Well-formed and equal to the reference: update the outputs, set `locked`, pulse `line_valid`, and go to LOCKED.
    - Well-formed but different: replace the reference and stay in VERIFY.
    - Malformed: go to MEASURE.
  - LOCKED. At each line start:
    - Equal: pulse `line_valid`.
    - Well-formed but different: clear `locked`, pulse `err`, store the new reference, and go to VERIFY.
    - Malformed: clear `locked`, pulse `err`, and go to MEASURE.
  - Overflow, in any state other than SEARCH: clear `locked`, pulse `err`, and go to SEARCH.
- The position outputs change only on the VERIFY→LOCKED transition. At all other times they hold their last locked values, including after lock is lost.
- All positions are unsigned c-bit values. No arithmetic beyond the counter increment and equality/ordering compares.

## Timing
- Reset:
  - State is SEARCH.
  - All position outputs are 0.
  - `locked`, `line_valid` and `err` are 0.
  - The edge history registers read as `blank`=0 and `sync`=0.
- Reset asserted in the middle of a line aborts the measurement. After release, no line start is recognised until `blank` has been sampled 1 and then 0.
- Latency is measured from the clock sampling the position-0 sample of the following line. `locked`, `line_valid`, `err` and the updated positions are valid 1 cycle later, registered.
- The earliest possible lock is 1 cycle after the third line start following reset.
- Overflow is reported 1 cycle after the sample that would have been position 2^c.
- When a sync rise and a blank rise occur on the same sample, the sync rise is legal but s_sync = s_blank, so the line is malformed.

## Configuration
- `VIDEO_TIMING_DETECT_SYNC_EN`
  - Defined: `blank` and `sync` each pass through a two-flop synchronizer before edge detection. All flag outputs are 2 cycles later. Measured positions are unchanged.
  - Undefined: inputs go directly to the single edge-history register, and latency is as stated under Timing.

## Structure
- Package `video_timing_pkg`:
  - State encoding: SEARCH, MEASURE, VERIFY, LOCKED.
  - Line-record layout: four c-bit positions.
  - Event-flag bit indices.
- One sub-module, `timing_edge_capture`, per input signal:
  - Holds the history register and generates rise/fall strobes.
  - Latches the current position on the first rise and the first fall.
  - Counts repeated edges for the well-formedness check.
- The top level holds the position counter, FSM, reference registers, compares and output registers.

## Test plan
All scenarios use c=8.
- Reset with `rst`=0 for 2 cycles, then a steady stream of s_blank=160, s_sync=176, r_sync=200, r_blank=223 → `locked` rises 1 cycle after the third line start; outputs read 160/176/200/223; `line_valid` pulses once per line thereafter.
- While locked, inject one line with s_sync=177 → `err` pulses and `locked` falls; outputs hold 176. `locked` rises again after 1 further matching line with s_sync=177, with outputs showing 177.
- While locked, inject a second sync pulse within one line → `err`, `locked`=0, state MEASURE. Relock takes 2 further clean lines.
- Hold `blank`=0 for 300 cycles after a line start → `err` pulses 1 cycle after position 256 would occur; state SEARCH; outputs unchanged.
- Assert `rst` in the middle of a line while locked → next cycle `locked`=0 and all outputs 0. Relock takes 3 line starts after release.
- With `VIDEO_TIMING_DETECT_SYNC_EN` defined, repeat scenario 1 → identical values, with `locked` 2 cycles later.
